pump_controller: RTL and testbench
==================================

# pump_controller

Closed-loop controller for the floating-switch water repository. It reads the 9-bit thermometer-coded level from the repository sensor, validates and debounces it, and drives `pump_activated` with start/stop hysteresis. It also supports cooldown, a no-progress timeout, and a sticky fault. It sits between the repository's `SensorOut` and its `pump_activated` input.

## Interface
Parameters:
- `START_LEVEL`, default 8: stable level (0..9) at or above which pumping starts.
- `STOP_LEVEL`, default 2: stable level at or below which pumping stops. Must be less than `START_LEVEL`.
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before the stable level updates. Must be at least 1.
- `COOLDOWN_CYCLES`, default 16: number of pump-off cycles spent in COOLDOWN.
- `MAX_RUN_CYCLES`, default 200: no-progress timeout while pumping.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits pumping.
- `clear_fault`  in  1  single-cycle pulse that exits FAULT.
- `SensorOut`  in  9  thermometer level code from the repository.
- `pump_activated`  out  1  pump drive.
- `level`  out  4  debounced stable level, 0..9.
- `fault`  out  1  high while in FAULT.
- `state`  out  2  FSM state encoding.

## Operation
- **Sampling:** `SensorOut` is registered every cycle into `sample`.
- **Decode:** a code is valid only if its ones are contiguous from bit 0 (`0`, `1`, `11`, …, `1FF`). Raw level equals the popcount of a valid code.
- **Debounce:**
  - `cand` holds the last decoded sample and `cnt` counts repeats.
  - If a new sample equals `cand`, `cnt` increments, saturating at `STABLE_CYCLES`. Otherwise `cand` takes the new sample and `cnt` becomes 1.
  - When `cnt` reaches `STABLE_CYCLES` and `cand` is valid, `level` takes `cand`'s level.
  - When `cnt` reaches `STABLE_CYCLES` and `cand` is invalid, the `bad_code` flag is raised.
- **FSM, encoded as IDLE=0, PUMP=1, COOLDOWN=2, FAULT=3:**
  - IDLE: pump off. Go to PUMP when `enable` is high and `level` ≥ `START_LEVEL`.
  - PUMP: pump on. Go to COOLDOWN when `level` ≤ `STOP_LEVEL` or `enable` is low.
  - COOLDOWN: pump off. A counter runs from 0 and returns to IDLE when it reaches `COOLDOWN_CYCLES-1`. `enable` is ignored during COOLDOWN.
  - FAULT: pump off and `fault` high. Go to IDLE on `clear_fault` only if the current `cand` is valid; otherwise remain in FAULT.
- **Priority:** `bad_code` forces FAULT from any state and has the highest priority. Next is the timeout, then the stop condition.
- **Simultaneous events:** if the stop condition and the timeout occur in the same cycle, the FSM goes to FAULT.
- **Counter widths:** each counter is `$clog2(limit+1)` bits wide and saturates; none wraps.
- **Reset:** takes effect mid-operation. Any pumping stops immediately because the reset is asynchronous.

## Timing
- **Reset values:**
  - `pump_activated` = 0, `fault` = 0, `level` = 0, `state` = IDLE.
  - `sample` = 0, `cand` = 0, `cnt` = 0, and all counters = 0.
- **Level latency:** if `SensorOut` changes before edge k, `sample` updates at edge k. `level` updates at edge k+`STABLE_CYCLES`-1, provided the input is held.
- **FSM latency:** the FSM reacts at the edge after `level` (or `bad_code`) updates. `pump_activated` is a registered decode of the state, so it changes in the same cycle as `state`.
- **Total input-to-pump latency:** `STABLE_CYCLES`+1 edges.
- **clear_fault:** sampled only in FAULT; ignored in all other states.
- **Glitch rejection:** an input glitch shorter than `STABLE_CYCLES` samples never changes `level`.

## Configuration
- **Macro:** `PUMP_CTRL_PROGRESS_TIMEOUT_EN`.
- **Defined:**
  - In PUMP, a run counter increments every cycle and clears whenever `level` decreases.
  - When the counter reaches `MAX_RUN_CYCLES`, the FSM goes to FAULT (dry pump or stuck sensor).
  - The counter clears on leaving PUMP.
- **Undefined:** the run counter and the timeout do not exist, and PUMP exits only through the stop condition, `enable` going low, or `bad_code`.

## Structure
- **Package `pump_ctrl_pkg`:**
  - State enum `pump_state_t` with IDLE, PUMP, COOLDOWN and FAULT.
  - `SENSOR_W=9`, `LEVEL_W=4`, `MAX_LEVEL=9`.
  - A function `thermo_valid` and a function `thermo_level`.
- **Sub-module `level_debouncer`:**
  - Contains sampling, decode and debounce.
  - Outputs `level` and `bad_code`.
  - The top level contains the FSM and its counters.

## Test plan
- **Reset and fill:** reset, hold `SensorOut`=0x1FF with `enable`=1 → `level`=9 after 4 sampled cycles, PUMP one edge later, `pump_activated`=1.
- **Closed loop:** connect to the repository model starting at level 100 → pump runs until `level`≤2, then COOLDOWN for 16 cycles, then IDLE.
- **Glitch rejection:** in IDLE at level 5, pulse `SensorOut`=0x1FF for 3 cycles → `level` stays 5 and the pump stays off.
- **Invalid code:** in PUMP, hold `SensorOut`=0x005 for 4 samples → FAULT, `fault`=1, pump off. Assert `clear_fault` while the code is still 0x005 → FAULT remains. Apply a valid code, then `clear_fault` → IDLE.
- **Timeout (macro defined):** hold `SensorOut`=0x1FF in PUMP for 200 cycles → FAULT. With the macro undefined, the same stimulus keeps the FSM in PUMP indefinitely.
- **Disable and mid-run reset:** drop `enable` in PUMP → COOLDOWN at the next edge. Assert `rst` mid-PUMP → `pump_activated`=0 immediately (asynchronously) and `state`=IDLE.

Source files
------------

// File: rtl/pump_ctrl_pkg.sv
// Shared types, widths and thermometer-code helpers for the pump controller.
package pump_ctrl_pkg;

  localparam int unsigned SENSOR_W  = 9;
  localparam int unsigned LEVEL_W   = 4;
  localparam int unsigned MAX_LEVEL = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PUMP     = 2'd1,
    COOLDOWN = 2'd2,
    FAULT    = 2'd3
  } pump_state_t;

  // A code is legal only when its ones form a contiguous run starting at bit 0
  function automatic logic thermo_valid(input logic [SENSOR_W-1:0] code);
    return (code & (code + SENSOR_W'(1))) == '0;
  endfunction

  // Level of a thermometer code is simply its popcount
  function automatic logic [LEVEL_W-1:0] thermo_level(input logic [SENSOR_W-1:0] code);
    logic [LEVEL_W-1:0] n;
    n = '0;
    for (int i = 0; i < SENSOR_W; i++) begin
      n = n + LEVEL_W'(code[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pump_controller_if.sv
// Sensor/command/status bundle between the water repository side and the controller.
interface pump_controller_if;
  import pump_ctrl_pkg::*;

  logic                enable;
  logic                clear_fault;
  logic [SENSOR_W-1:0] SensorOut;
  logic                pump_activated;
  logic [LEVEL_W-1:0]  level;
  logic                fault;
  pump_state_t         state;

  modport master (
    output enable, clear_fault, SensorOut,
    input  pump_activated, level, fault, state
  );

  modport slave (
    input  enable, clear_fault, SensorOut,
    output pump_activated, level, fault, state
  );
endinterface

// File: rtl/pump_controller_level_debouncer.sv
// Samples the thermometer sensor, decodes it and publishes a debounced level
// plus a flag for a persistently illegal code.
module level_debouncer
  import pump_ctrl_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SENSOR_W-1:0] sensor_i,
  output logic [LEVEL_W-1:0]  level_o,
  output logic                bad_code_o,
  output logic                cand_valid_o
);

  localparam int unsigned      CNT_W   = (STABLE_CYCLES > 0) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  // The sample register doubles as the debounce candidate: both take every new sample
  logic [SENSOR_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                bad_q, bad_d;
  logic                cand_valid_q, cand_valid_d;
  logic                new_valid_c;
  logic                stable_c;

  // Count repeats of the incoming sample and qualify it once it has held long enough
  always_comb begin
    cand_d       = sensor_i;
    new_valid_c  = thermo_valid(sensor_i);
    cand_valid_d = new_valid_c;
    cnt_d        = CNT_W'(1);
    level_d      = level_q;
    if (sensor_i == cand_q) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
    stable_c = (cnt_d == CNT_MAX);
    if (stable_c && new_valid_c) begin
      level_d = thermo_level(sensor_i);
    end
    bad_d = stable_c && !new_valid_c;
  end

  // Sample, repeat counter and qualified outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q       <= '0;
      cnt_q        <= '0;
      level_q      <= '0;
      bad_q        <= 1'b0;
      cand_valid_q <= 1'b1;
    end else begin
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      bad_q        <= bad_d;
      cand_valid_q <= cand_valid_d;
    end
  end

  assign level_o      = level_q;
  assign bad_code_o   = bad_q;
  assign cand_valid_o = cand_valid_q;

endmodule

// File: rtl/pump_controller.sv
// Closed-loop pump controller: debounced level in, hysteretic pump drive out,
// with cooldown and a sticky fault state.
// Optional feature macro: PUMP_CTRL_PROGRESS_TIMEOUT_EN adds a no-progress
// timeout while pumping.
module pump_controller
  import pump_ctrl_pkg::*;
#(
  parameter int unsigned START_LEVEL     = 8,
  parameter int unsigned STOP_LEVEL      = 2,
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned COOLDOWN_CYCLES = 16,
  parameter int unsigned MAX_RUN_CYCLES  = 200
) (
  input logic             clk,
  input logic             rst,
  pump_controller_if.slave bus
);

  if (STOP_LEVEL >= START_LEVEL || START_LEVEL > MAX_LEVEL ||
      STABLE_CYCLES == 0 || MAX_RUN_CYCLES == 0) begin : g_param_check
    $error("pump_controller: illegal parameter set");
  end

  localparam int unsigned       CD_W      = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CD_W-1:0]   CD_MAX    = CD_W'(COOLDOWN_CYCLES);
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);
  localparam logic [LEVEL_W-1:0] START_LVL = LEVEL_W'(START_LEVEL);
  localparam logic [LEVEL_W-1:0] STOP_LVL  = LEVEL_W'(STOP_LEVEL);

  logic [LEVEL_W-1:0] level_w;
  logic               bad_code_w;
  logic               cand_valid_w;

  pump_state_t        state_q, state_d;
  logic               pump_q, pump_d;
  logic               fault_q, fault_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               timeout_c;

  level_debouncer #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .sensor_i     (bus.SensorOut),
    .level_o      (level_w),
    .bad_code_o   (bad_code_w),
    .cand_valid_o (cand_valid_w)
  );

`ifdef PUMP_CTRL_PROGRESS_TIMEOUT_EN
  localparam int unsigned     RUN_W    = $clog2(MAX_RUN_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN_CYCLES);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);

  logic [RUN_W-1:0]   run_q, run_d;
  logic [LEVEL_W-1:0] level_prev_q;
  logic               level_dec_c;

  // A falling level is progress; otherwise a full run budget in PUMP means a dry pump or stuck sensor
  always_comb begin
    level_dec_c = (level_w < level_prev_q);
    timeout_c   = (state_q == PUMP) && !level_dec_c && (run_q >= RUN_LAST);
  end

  // Run counter lives only while PUMP continues, restarting on each level drop
  always_comb begin
    run_d = '0;
    if (state_q == PUMP && state_d == PUMP && !level_dec_c) begin
      run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    end
  end

  // Run counter and previous level registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q        <= '0;
      level_prev_q <= '0;
    end else begin
      run_q        <= run_d;
      level_prev_q <= level_w;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next-state logic: bad code beats timeout beats the stop condition
  always_comb begin
    state_d = state_q;
    if (bad_code_w) begin
      state_d = FAULT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.enable && level_w >= START_LVL) state_d = PUMP;
        end
        PUMP: begin
          if (timeout_c) begin
            state_d = FAULT;
          end else if (level_w <= STOP_LVL || !bus.enable) begin
            state_d = COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (cd_q >= CD_LAST) state_d = IDLE;
        end
        FAULT: begin
          if (bus.clear_fault && cand_valid_w) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs decode the upcoming state so they move with it
  always_comb begin
    pump_d  = (state_d == PUMP);
    fault_d = (state_d == FAULT);
  end

  // Cooldown counter counts pump-off cycles spent in COOLDOWN
  always_comb begin
    cd_d = '0;
    if (state_q == COOLDOWN && state_d == COOLDOWN) begin
      cd_d = (cd_q == CD_MAX) ? cd_q : cd_q + CD_W'(1);
    end
  end

  // State, output and cooldown registers; reset drops the pump asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pump_q  <= 1'b0;
      fault_q <= 1'b0;
      cd_q    <= '0;
    end else begin
      state_q <= state_d;
      pump_q  <= pump_d;
      fault_q <= fault_d;
      cd_q    <= cd_d;
    end
  end

  assign bus.pump_activated = pump_q;
  assign bus.fault          = fault_q;
  assign bus.state          = state_q;
  assign bus.level          = level_w;

endmodule

// File: tb/tb_pump_controller.sv
// Self-checking bench for pump_controller against a window-based reference model.
module tb_pump_controller;
  import pump_ctrl_pkg::*;

  localparam int SC     = 4;
  localparam int START  = 8;
  localparam int STOP   = 2;
  localparam int CD     = 16;
  localparam int MAXRUN = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pump_controller_if bus();

  pump_controller #(
    .START_LEVEL     (START),
    .STOP_LEVEL      (STOP),
    .STABLE_CYCLES   (SC),
    .COOLDOWN_CYCLES (CD),
    .MAX_RUN_CYCLES  (MAXRUN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [8:0] hist [SC];
  int n_seen, m_level, m_state, m_cool, m_prev_level;
  bit m_bad;
`ifdef PUMP_CTRL_PROGRESS_TIMEOUT_EN
  int m_run;
`endif

  function automatic int ones(input logic [8:0] c);
    int n = 0;
    for (int i = 0; i < 9; i++) if (c[i]) n++;
    return n;
  endfunction

  function automatic bit code_ok(input logic [8:0] c);
    logic [8:0] full;
    full = '1;
    return c == (full >> (9 - ones(c)));
  endfunction

  // true when the last SC samples since reset (including s) are identical
  function automatic bit held(input logic [8:0] s);
    if (n_seen + 1 < SC) return 1'b0;
    for (int i = 0; i < SC - 1; i++) if (hist[i] !== s) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_next();
    bit timed_out = 1'b0;
`ifdef PUMP_CTRL_PROGRESS_TIMEOUT_EN
    timed_out = (m_state == 1) && !(m_level < m_prev_level) && (m_run + 1 >= MAXRUN);
`endif
    if (m_bad) return 3;
    case (m_state)
      0: return (bus.enable && m_level >= START) ? 1 : 0;
      1: begin
        if (timed_out) return 3;
        return (m_level <= STOP || !bus.enable) ? 2 : 1;
      end
      2: return (m_cool + 1 >= CD) ? 0 : 2;
      default: return (bus.clear_fault && code_ok(hist[0])) ? 0 : 3;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SC; i++) hist[i] <= '0;
      n_seen <= 0; m_level <= 0; m_bad <= 1'b0; m_state <= 0; m_cool <= 0; m_prev_level <= 0;
`ifdef PUMP_CTRL_PROGRESS_TIMEOUT_EN
      m_run <= 0;
`endif
    end else begin
      m_state      <= model_next();
      m_cool       <= (m_state == 2 && model_next() == 2) ? m_cool + 1 : 0;
`ifdef PUMP_CTRL_PROGRESS_TIMEOUT_EN
      m_run        <= (m_state == 1 && model_next() == 1 && m_level >= m_prev_level) ? m_run + 1 : 0;
`endif
      m_prev_level <= m_level;
      if (held(bus.SensorOut) && code_ok(bus.SensorOut)) m_level <= ones(bus.SensorOut);
      m_bad        <= held(bus.SensorOut) && !code_ok(bus.SensorOut);
      hist[0]      <= bus.SensorOut;
      for (int i = 1; i < SC; i++) hist[i] <= hist[i-1];
      if (n_seen < 1000) n_seen <= n_seen + 1;
    end
  end

  function automatic logic [7:0] exp_vec();
    return {2'(m_state), m_state == 1, m_state == 3, 4'(m_level)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.state, bus.pump_activated, bus.fault, bus.level};
  endfunction

  function automatic logic [8:0] tank_code(input int w);
    int l = w / 10;
    if (l > 9) l = 9;
    return 9'((1 << l) - 1);
  endfunction

  // ---------------- helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.SensorOut = '0; bus.enable = 1'b0; bus.clear_fault = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.SensorOut = '0; bus.enable = 1'b0; bus.clear_fault = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d want=0", bus.state); end
    n_checks++;
    if (bus.pump_activated !== 1'b0) begin n_fail++; $display("FAIL reset_pump got=%b want=0", bus.pump_activated); end
    n_checks++;
    if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got=%b want=0", bus.fault); end
    n_checks++;
    if (bus.level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    rst = 1'b0;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL reset_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_fill();
    bus.SensorOut = 9'h1FF; bus.enable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL fill_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec()); end
      if (c == 3) begin
        n_checks++;
        if (bus.level !== 4'd0) begin n_fail++; $display("FAIL fill_early_level got=%0d want=0", bus.level); end
      end
      if (c == 4) begin
        n_checks++;
        if ({bus.level, bus.state} !== {4'd9, IDLE}) begin
          n_fail++; $display("FAIL fill_level9 got=%0d/%0d want=9/0", bus.level, bus.state);
        end
      end
      if (c == 5) begin
        n_checks++;
        if ({bus.state, bus.pump_activated} !== {PUMP, 1'b1}) begin
          n_fail++; $display("FAIL fill_pump got=%0d/%b want=1/1", bus.state, bus.pump_activated);
        end
      end
    end
  endtask

  task automatic test_glitch();
    bus.SensorOut = 9'h01F; bus.enable = 1'b0;
    repeat (25) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL glitch_settle got=%h want=%h", dut_vec(), exp_vec()); end
    end
    bus.enable = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({bus.state, bus.level} !== {IDLE, 4'd5}) begin
      n_fail++; $display("FAIL glitch_idle5 got=%0d/%0d want=0/5", bus.state, bus.level);
    end
    for (int c = 0; c < 11; c++) begin
      bus.SensorOut = (c < 3) ? 9'h1FF : 9'h01F;
      tick();
      n_checks++;
      if ({bus.level, bus.pump_activated} !== {4'd5, 1'b0}) begin
        n_fail++; $display("FAIL glitch_hold c=%0d got=%0d/%b want=5/0", c, bus.level, bus.pump_activated);
      end
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL glitch_model got=%h want=%h", dut_vec(), exp_vec()); end
    end
  endtask

  task automatic test_disable_reset();
    bit got;
    bus.SensorOut = 9'h1FF; bus.enable = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = (bus.state == PUMP);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL dis_reach_pump got=%0d want=1", bus.state); end
    bus.enable = 1'b0;
    tick();
    n_checks++;
    if ({bus.state, bus.pump_activated} !== {COOLDOWN, 1'b0}) begin
      n_fail++; $display("FAIL dis_cooldown got=%0d/%b want=2/0", bus.state, bus.pump_activated);
    end
    bus.enable = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL dis_model got=%h want=%h", dut_vec(), exp_vec()); end
      got = (bus.state == PUMP);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL dis_repump got=%0d want=1", bus.state); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.pump_activated, bus.state, bus.fault} !== {1'b0, IDLE, 1'b0}) begin
      n_fail++; $display("FAIL async_reset got=%b/%0d/%b want=0/0/0", bus.pump_activated, bus.state, bus.fault);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL post_reset_model got=%h want=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_invalid();
    bit got;
    bus.SensorOut = 9'h1FF; bus.enable = 1'b1; bus.clear_fault = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = (bus.state == PUMP);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL inv_reach_pump got=%0d want=1", bus.state); end
    bus.SensorOut = 9'h005;
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL inv_model t=%0d got=%h want=%h", t, dut_vec(), exp_vec()); end
      if (t == 4) begin
        n_checks++;
        if (bus.state !== PUMP) begin n_fail++; $display("FAIL inv_still_pump got=%0d want=1", bus.state); end
      end
    end
    n_checks++;
    if ({bus.state, bus.fault, bus.pump_activated, bus.level} !== {FAULT, 1'b1, 1'b0, 4'd9}) begin
      n_fail++; $display("FAIL inv_fault got=%0d/%b/%b/%0d want=3/1/0/9", bus.state, bus.fault, bus.pump_activated, bus.level);
    end
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    n_checks++;
    if (bus.state !== FAULT) begin n_fail++; $display("FAIL inv_clear_bad got=%0d want=3", bus.state); end
    bus.SensorOut = 9'h003; bus.enable = 1'b0;
    tick();
    n_checks++;
    if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL inv_valid_model got=%h want=%h", dut_vec(), exp_vec()); end
    bus.clear_fault = 1'b1;
    tick();
    bus.clear_fault = 1'b0;
    n_checks++;
    if ({bus.state, bus.fault} !== {IDLE, 1'b0}) begin
      n_fail++; $display("FAIL inv_clear_ok got=%0d/%b want=0/0", bus.state, bus.fault);
    end
  endtask

  task automatic test_timeout();
    bit got;
    int n;
    do_reset();
    bus.SensorOut = 9'h1FF; bus.enable = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = (bus.state == PUMP);
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL to_reach_pump got=%0d want=1", bus.state); end
    n = 1;
`ifdef PUMP_CTRL_PROGRESS_TIMEOUT_EN
    for (int c = 0; c < 300 && bus.state == PUMP; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL to_model got=%h want=%h", dut_vec(), exp_vec()); end
      if (bus.state == PUMP) n++;
    end
    n_checks++;
    if ({bus.state, bus.fault} !== {FAULT, 1'b1} || n != MAXRUN) begin
      n_fail++; $display("FAIL timeout got=%0d/%b after %0d pump cycles want=3/1 after %0d", bus.state, bus.fault, n, MAXRUN);
    end
`else
    for (int c = 0; c < 250; c++) begin
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL to_model got=%h want=%h", dut_vec(), exp_vec()); end
      if (bus.state == PUMP) n++;
    end
    n_checks++;
    if (n != 251) begin n_fail++; $display("FAIL no_timeout pump cycles got=%0d want=251", n); end
`endif
  endtask

  task automatic test_closed_loop();
    int  w, cool_n;
    bit  saw_pump, finished;
    do_reset();
    bus.enable = 1'b1;
    w = 100; cool_n = 0; saw_pump = 1'b0; finished = 1'b0;
    for (int c = 0; c < 600 && !finished; c++) begin
      bus.SensorOut = tank_code(w);
      tick();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL loop_model c=%0d got=%h want=%h", c, dut_vec(), exp_vec()); end
      if (bus.state == PUMP) begin
        saw_pump = 1'b1;
        w = w - int'($urandom_range(0, 2));
        if (w < 0) w = 0;
      end
      if (bus.state == COOLDOWN) cool_n++;
      if (saw_pump && cool_n > 0 && bus.state == IDLE) finished = 1'b1;
    end
    n_checks++;
    if (!finished || cool_n != CD) begin
      n_fail++; $display("FAIL loop_cycle done=%b cooldown=%0d want done=1 cooldown=%0d", finished, cool_n, CD);
    end
    n_checks++;
    if (bus.level > 4'(STOP)) begin n_fail++; $display("FAIL loop_stop_level got=%0d want<=%0d", bus.level, STOP); end
  endtask

  task automatic test_random();
    int         lvl, hold;
    logic [8:0] code;
    do_reset();
    for (int blk = 0; blk < 150; blk++) begin
      lvl  = int'($urandom_range(0, 9));
      code = ($urandom_range(0, 99) < 85) ? 9'((1 << lvl) - 1) : 9'($urandom_range(0, 511));
      hold = int'($urandom_range(1, 6));
      for (int h = 0; h < hold; h++) begin
        bus.SensorOut   = code;
        bus.enable      = ($urandom_range(0, 9) != 0);
        bus.clear_fault = ($urandom_range(0, 9) == 0);
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL random_model blk=%0d code=%h got=%h want=%h", blk, code, dut_vec(), exp_vec());
        end
      end
    end
    bus.clear_fault = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SensorOut = '0; bus.enable = 1'b0; bus.clear_fault = 1'b0;
    test_reset();
    test_fill();
    test_glitch();
    test_disable_reset();
    test_invalid();
    test_timeout();
    test_closed_loop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
